// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared defaults, width helpers and result type for conv_mac_stream.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int c_def_ksize     = 3;
  localparam int c_def_pix_w     = 8;
  localparam int c_def_coef_w    = 16;
  localparam int c_def_frac_bits = 4;
  localparam int c_def_ch_in     = 1;
  localparam int c_def_acc_w     = 32;
  localparam int c_def_out_w     = 8;

  // Widest output pixel the result type can carry.
  localparam int c_res_pix_w     = 32;

  function automatic int prod_w(input int pix_w, input int coef_w);
    return pix_w + 1 + coef_w;
  endfunction

  function automatic int tree_w(input int pix_w, input int coef_w, input int ksize);
    return prod_w(pix_w, coef_w) + $clog2(ksize * ksize);
  endfunction

  function automatic int min_acc_w(input int pix_w, input int coef_w,
                                   input int ksize, input int ch_in);
    return prod_w(pix_w, coef_w) + $clog2(ksize * ksize * ch_in) + 1;
  endfunction

  typedef struct packed {
    logic [c_res_pix_w-1:0] pix;
    logic                   sat;
  } conv_result_t;

endpackage
`default_nettype wire

// File: rtl/conv_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : conv_adder_tree
// Brief    : Combinational signed adder tree, N_IN operands padded to a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int IN_W  = 25,
  parameter int OUT_W = 29
) (
  input  logic [N_IN-1:0][IN_W-1:0] i_operands,
  output logic signed [OUT_W-1:0]   o_sum
);

  localparam int c_levels = (N_IN > 1) ? $clog2(N_IN) : 0;
  localparam int c_leaves = 1 << c_levels;

  genvar gl, gj;
  generate
    for (gl = 0; gl <= c_levels; gl++) begin : g_lvl
      localparam int c_n = c_leaves >> gl;
      logic signed [OUT_W-1:0] w_val [c_n];
      for (gj = 0; gj < c_n; gj++) begin : g_elem
        if (gl == 0) begin : g_leaf
          if (gj < N_IN) begin : g_used
            assign w_val[gj] = OUT_W'($signed(i_operands[gj]));
          end else begin : g_pad
            assign w_val[gj] = '0;
          end
        end else begin : g_add
          assign w_val[gj] = g_lvl[gl-1].w_val[2*gj] + g_lvl[gl-1].w_val[2*gj+1];
        end
      end
    end
  endgenerate

  assign o_sum = g_lvl[c_levels].w_val[0];

endmodule
`default_nettype wire

// File: rtl/conv_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_stream
// Brief    : 4-stage K x K multi-channel convolution MAC with bias, rescale and
//            unsigned saturation. Define CONV_ROUND_EN for round-half-up scaling.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_stream
  import conv_pkg::*;
#(
  parameter int KSIZE     = c_def_ksize,
  parameter int PIX_W     = c_def_pix_w,
  parameter int COEF_W    = c_def_coef_w,
  parameter int FRAC_BITS = c_def_frac_bits,
  parameter int CH_IN     = c_def_ch_in,
  parameter int ACC_W     = c_def_acc_w,
  parameter int OUT_W     = c_def_out_w
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0]  win_i,
  input  logic [KSIZE-1:0][KSIZE-1:0][COEF_W-1:0] k_i,
  input  logic signed [ACC_W-1:0]              bias_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 clear_i,
  output logic [OUT_W-1:0]                     pix_o,
  output logic                                 sat_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i
);

  localparam int c_taps   = KSIZE * KSIZE;
  localparam int c_prod_w = prod_w(PIX_W, COEF_W);
  localparam int c_tree_w = tree_w(PIX_W, COEF_W, KSIZE);
  localparam int c_ch_w   = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam logic [c_ch_w-1:0]     c_last_ch = c_ch_w'(CH_IN - 1);
  localparam logic signed [ACC_W:0] c_pix_max = (ACC_W+1)'((1 << OUT_W) - 1);

  generate
    if (ACC_W < min_acc_w(PIX_W, COEF_W, KSIZE, CH_IN)) begin : g_chk_acc
      $error("conv_mac_stream: ACC_W too narrow for the worst-case accumulation");
    end
    if (KSIZE < 1 || CH_IN < 1 || FRAC_BITS < 1) begin : g_chk_range
      $error("conv_mac_stream: KSIZE, CH_IN and FRAC_BITS must be at least 1");
    end
    if (OUT_W > c_res_pix_w || OUT_W >= ACC_W) begin : g_chk_out
      $error("conv_mac_stream: OUT_W out of range");
    end
  endgenerate

  logic                              w_adv;
  logic                              w_accept;
  logic [c_taps-1:0][c_prod_w-1:0]   w_prod;
  logic [c_taps-1:0][c_prod_w-1:0]   r_prod;
  logic                              r_s1_v;
  logic                              r_s2_v;
  logic                              r_s3_v;
  logic signed [ACC_W-1:0]           r_s1_bias;
  logic signed [ACC_W-1:0]           r_s2_bias;
  logic signed [c_tree_w-1:0]        w_sum;
  logic signed [c_tree_w-1:0]        r_sum;
  logic signed [ACC_W-1:0]           w_sum_ext;
  logic signed [ACC_W-1:0]           r_acc;
  logic [c_ch_w-1:0]                 r_ch;
  logic signed [ACC_W:0]             w_acc_rnd;
  logic signed [ACC_W:0]             w_scaled;
  conv_result_t                      w_res;
  logic [OUT_W-1:0]                  r_pix;
  logic                              r_sat;
  logic                              r_out_valid;

  // The whole pipeline moves in lock-step; only a held output can stall it.
  assign w_adv      = ~r_out_valid | out_ready_i;
  assign in_ready_o = w_adv & ~clear_i;
  assign w_accept   = in_valid_i & in_ready_o;

  genvar gr, gc;
  generate
    for (gr = 0; gr < KSIZE; gr++) begin : g_row
      for (gc = 0; gc < KSIZE; gc++) begin : g_col
        logic signed [c_prod_w-1:0] w_k_ext;
        logic signed [c_prod_w-1:0] w_p_ext;
        assign w_k_ext = c_prod_w'($signed(k_i[gr][gc]));
        assign w_p_ext = c_prod_w'({1'b0, win_i[gr][gc]});
        assign w_prod[gr*KSIZE+gc] = w_k_ext * w_p_ext;
      end
    end
  endgenerate

  conv_adder_tree #(
    .N_IN  (c_taps),
    .IN_W  (c_prod_w),
    .OUT_W (c_tree_w)
  ) u_tree (
    .i_operands (r_prod),
    .o_sum      (w_sum)
  );

  assign w_sum_ext = ACC_W'(r_sum);

  always_comb begin
    w_acc_rnd = (ACC_W+1)'(r_acc);
`ifdef CONV_ROUND_EN
    w_acc_rnd = w_acc_rnd + (ACC_W+1)'(1 << (FRAC_BITS - 1));
`endif
    w_scaled = w_acc_rnd >>> FRAC_BITS;
    w_res    = '0;
    if (w_scaled < 0) begin
      w_res.sat = 1'b1;
    end else if (w_scaled > c_pix_max) begin
      w_res.pix = c_res_pix_w'(c_pix_max);
      w_res.sat = 1'b1;
    end else begin
      w_res.pix = c_res_pix_w'(w_scaled);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prod      <= '0;
      r_s1_bias   <= '0;
      r_s2_bias   <= '0;
      r_sum       <= '0;
      r_acc       <= '0;
      r_ch        <= '0;
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s3_v      <= 1'b0;
      r_pix       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prod    <= w_prod;
        r_s1_bias <= bias_i;
      end
      if (w_adv && r_s1_v) begin
        r_sum     <= w_sum;
        r_s2_bias <= r_s1_bias;
      end

      if (clear_i) begin
        r_s1_v <= 1'b0;
        r_s2_v <= 1'b0;
        r_s3_v <= 1'b0;
        r_ch   <= '0;
        r_acc  <= '0;
      end else if (w_adv) begin
        r_s1_v <= w_accept;
        r_s2_v <= r_s1_v;
        r_s3_v <= r_s2_v && (r_ch == c_last_ch);
        if (r_s2_v) begin
          r_acc <= (r_ch == '0) ? w_sum_ext + r_s2_bias : r_acc + w_sum_ext;
          r_ch  <= (r_ch == c_last_ch) ? '0 : r_ch + 1'b1;
        end
      end

      // A finished sum caught by an abort is dropped rather than emitted.
      if (w_adv) begin
        r_out_valid <= r_s3_v & ~clear_i;
        if (r_s3_v && !clear_i) begin
          r_pix <= w_res.pix[OUT_W-1:0];
          r_sat <= w_res.sat;
        end
      end
    end
  end

  assign pix_o       = r_pix;
  assign sat_o       = r_sat;
  assign out_valid_o = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mac_stream
// Brief    : Directed self-checking bench; one CH_IN=1 and one CH_IN=3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mac_stream;

  localparam int K  = 3;
  localparam int PW = 8;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int NV = 11;
`ifdef CONV_ROUND_EN
  localparam bit c_round = 1'b1;
`else
  localparam bit c_round = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [K-1:0][K-1:0][PW-1:0] win;
  logic [K-1:0][K-1:0][CW-1:0] kern;
  logic [AW-1:0] bias;
  logic in_valid, clear, out_ready, sel;
  logic ir1, ov1, sat1, ir3, ov3, sat3;
  logic [OW-1:0] pix1, pix3;

  always #5 clk = ~clk;

  conv_mac_stream #(.KSIZE(K), .PIX_W(PW), .COEF_W(CW), .FRAC_BITS(4),
                    .CH_IN(1), .ACC_W(AW), .OUT_W(OW)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .win_i(win), .k_i(kern), .bias_i(bias),
    .in_valid_i(in_valid & ~sel), .in_ready_o(ir1), .clear_i(clear & ~sel),
    .pix_o(pix1), .sat_o(sat1), .out_valid_o(ov1), .out_ready_i(out_ready));

  conv_mac_stream #(.KSIZE(K), .PIX_W(PW), .COEF_W(CW), .FRAC_BITS(4),
                    .CH_IN(3), .ACC_W(AW), .OUT_W(OW)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .win_i(win), .k_i(kern), .bias_i(bias),
    .in_valid_i(in_valid & sel), .in_ready_o(ir3), .clear_i(clear & sel),
    .pix_o(pix3), .sat_o(sat3), .out_valid_o(ov3), .out_ready_i(out_ready));

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int q1_pix[$], q1_sat[$], q1_cyc[$], q3_pix[$], q3_sat[$];
  logic prev_stall1 = 1'b0, prev_stall3 = 1'b0;
  logic [OW-1:0] prev_pix1, prev_pix3;

  typedef struct {
    int c_all, c_cen, p_all, p_cen, b;
    int pix_t, sat_t, pix_r, sat_r;
  } vec_t;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sample on the falling edge: record pops and check output hold under stall.
  always @(negedge clk) begin
    if (prev_stall1) check("hold_pix1", int'(pix1), int'(prev_pix1));
    if (prev_stall3) check("hold_pix3", int'(pix3), int'(prev_pix3));
    prev_stall1 = ov1 & ~out_ready;
    prev_stall3 = ov3 & ~out_ready;
    prev_pix1   = pix1;
    prev_pix3   = pix3;
    if (ov1 && out_ready) begin
      q1_pix.push_back(int'(pix1)); q1_sat.push_back(int'(sat1)); q1_cyc.push_back(cyc);
    end
    if (ov3 && out_ready) begin
      q3_pix.push_back(int'(pix3)); q3_sat.push_back(int'(sat3));
    end
  end

  task automatic set_beat(input int c_all, input int c_cen, input int p_all,
                          input int p_cen, input int b);
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win[r][c]  = PW'(p_all);
        kern[r][c] = CW'(c_all);
      end
    end
    win[1][1]  = PW'(p_cen);
    kern[1][1] = CW'(c_cen);
    bias       = AW'(b);
  endtask

  // Returns #1 after the accepting edge with in_valid still high.
  task automatic send_beat(input int c_all, input int c_cen, input int p_all,
                           input int p_cen, input int b);
    logic ok;
    set_beat(c_all, c_cen, p_all, p_cen, b);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = sel ? ir3 : ir1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input bit which3, input int n, input string name);
    for (int i = 0; i < 200; i++) begin
      if ((which3 ? q3_pix.size() : q1_pix.size()) >= n) break;
      @(posedge clk);
    end
    #1;
    check(name, which3 ? q3_pix.size() : q1_pix.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc_cyc, exp_p, exp_s;
    logic saw_low;

    // c_all, c_cen, p_all, p_cen, bias, pix/sat truncating, pix/sat rounding
    vecs[0]  = '{0,   16,   7, 100,   0, 100, 0, 100, 0};
    vecs[1]  = '{-16, -16, 10,  10,   0,   0, 1,   0, 1};
    vecs[2]  = '{16,  16, 255, 255,   0, 255, 1, 255, 1};
    vecs[3]  = '{0,    8,   5,   3,   0,   1, 0,   2, 0};
    vecs[4]  = '{0,   16,   9,  20,  80,  25, 0,  25, 0};
    vecs[5]  = '{0,   -1,   9,   8,   0,   0, 1,   0, 0};
    vecs[6]  = '{0,   16, 200, 255,   0, 255, 0, 255, 0};
    vecs[7]  = '{0,   16,   0, 255,  16, 255, 1, 255, 1};
    vecs[8]  = '{0,    0,   3,   3,   0,   0, 0,   0, 0};
    vecs[9]  = '{1,   16,  16,  10,   0,  18, 0,  18, 0};
    vecs[10] = '{0,   16,   0,  50, -32,  48, 0,  48, 0};

    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1; sel = 1'b0;
    set_beat(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix1", int'(pix1), 0);
    check("rst_sat1", int'(sat1), 0);
    check("rst_valid1", int'(ov1), 0);
    check("rst_ready1", int'(ir1), 1);
    check("rst_valid3", int'(ov3), 0);
    check("rst_ready3", int'(ir3), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-channel vectors; accepting edge counts as the 1st, output rises on the 4th.
    for (int i = 0; i < NV; i++) begin
      base = q1_pix.size();
      send_beat(vecs[i].c_all, vecs[i].c_cen, vecs[i].p_all, vecs[i].p_cen, vecs[i].b);
      in_valid = 1'b0;
      acc_cyc  = cyc;
      exp_p = c_round ? vecs[i].pix_r : vecs[i].pix_t;
      exp_s = c_round ? vecs[i].sat_r : vecs[i].sat_t;
      wait_q(0, base + 1, $sformatf("vec%0d_count", i));
      if (q1_pix.size() > base) begin
        check($sformatf("vec%0d_pix", i), q1_pix[base], exp_p);
        check($sformatf("vec%0d_sat", i), q1_sat[base], exp_s);
        check($sformatf("vec%0d_latency", i), q1_cyc[base] - acc_cyc, 3);
      end
    end

    // Three-channel accumulation; only the first beat's bias counts.
    sel = 1'b1;
    base = q3_pix.size();
    send_beat(0, 16, 0, 50, 160);
    send_beat(0, 16, 0, 60, 999);
    send_beat(0, 16, 0, 70, -555);
    idle(1);
    wait_q(1, base + 1, "mc_count");
    if (q3_pix.size() > base) begin
      check("mc_pix", q3_pix[base], 190);
      check("mc_sat", q3_sat[base], 0);
    end

    base = q3_pix.size();
    send_beat(0, 16, 0, 50, 160); idle(2);
    send_beat(0, 16, 0, 60, 0);   idle(2);
    send_beat(0, 16, 0, 70, 0);   idle(1);
    wait_q(1, base + 1, "bubble_count");
    if (q3_pix.size() > base) check("bubble_pix", q3_pix[base], 190);

    base = q3_pix.size();
    send_beat(0, 16, 0, 10, 0);
    send_beat(0, 16, 0, 20, 0);
    send_beat(0, 16, 0, 30, 0);
    send_beat(0, 16, 0, 100, -80);
    send_beat(0, 16, 0, 100, 0);
    send_beat(0, 16, 0, 100, 0);
    idle(1);
    wait_q(1, base + 2, "b2b_count");
    if (q3_pix.size() > base + 1) begin
      check("b2b_pix0", q3_pix[base], 60);
      check("b2b_pix1", q3_pix[base+1], 255);
      check("b2b_sat1", q3_sat[base+1], 1);
    end

    // Backpressure with back-to-back single-channel beats.
    sel = 1'b0;
    base = q1_pix.size();
    saw_low = 1'b0;
    fork
      begin
        for (int j = 1; j <= 8; j++) send_beat(0, 16, 0, j * 10, 0);
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        for (int n = 0; n < 50 && !ov1; n++) @(negedge clk);
        for (int n = 0; n < 6; n++) begin
          @(negedge clk);
          if (!ir1) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("bp_ready_drop", int'(saw_low), 1);
    wait_q(0, base + 8, "bp_count");
    idle(10);
    check("bp_no_dup", q1_pix.size(), base + 8);
    if (q1_pix.size() >= base + 8) begin
      for (int j = 0; j < 8; j++) check($sformatf("bp_pix%0d", j), q1_pix[base+j], (j + 1) * 10);
    end

    // Abort after two of three channels; the beat offered with clear is refused.
    sel = 1'b1;
    base = q3_pix.size();
    send_beat(0, 16, 0, 50, 160);
    send_beat(0, 16, 0, 60, 0);
    set_beat(0, 16, 0, 99, 0);
    in_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    check("clear_blocks_in", int'(ir3), 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    send_beat(0, 16, 0, 10, 0);
    send_beat(0, 16, 0, 20, 0);
    send_beat(0, 16, 0, 30, 0);
    idle(12);
    check("clear_count", q3_pix.size(), base + 1);
    if (q3_pix.size() > base) check("clear_pix", q3_pix[base], 60);

    // Same sequence interrupted by an asynchronous reset pulse.
    base = q3_pix.size();
    send_beat(0, 16, 0, 50, 160);
    send_beat(0, 16, 0, 60, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mrst_pix3", int'(pix3), 0);
    check("mrst_sat3", int'(sat3), 0);
    check("mrst_valid3", int'(ov3), 0);
    check("mrst_ready3", int'(ir3), 1);
    check("mrst_pix1", int'(pix1), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(0, 16, 0, 10, 0);
    send_beat(0, 16, 0, 20, 0);
    send_beat(0, 16, 0, 30, 0);
    idle(12);
    check("mrst_count", q3_pix.size(), base + 1);
    if (q3_pix.size() > base) check("mrst_pix", q3_pix[base], 60);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
